// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit ALU with registered result/flags and an iterative shift-add multiplier.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, sel (operation in);
//        out_valid/out_ready with result, carry, overflow, zero, negative, illegal (registered out).
module alu_pipe #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             illegal
);
    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t state, state_d;
    logic [2*WIDTH-1:0] mcand, acc, prod;
    logic [WIDTH-1:0] mplier, alu_res, res_d;
    logic [SHW-1:0] count;
    logic [WIDTH:0] add_s, sub_s;
    logic alu_c, alu_v, alu_ill, last, out_free, accept, mul_done, load;
    always_comb begin
        add_s = {1'b0, a} + {1'b0, b};
        sub_s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        alu_res = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        alu_ill = 1'b0;
        case (sel)
            4'd0: alu_res = a & b;
            4'd1: alu_res = a | b;
            4'd2: alu_res = a ^ b;
            4'd3: begin
                alu_res = add_s[WIDTH-1:0];
                alu_c = add_s[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            4'd4: begin
                alu_res = sub_s[WIDTH-1:0];
                alu_c = sub_s[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            4'd5: alu_res = a << b[SHW-1:0];
            4'd6: alu_res = a >> b[SHW-1:0];
            4'd7: alu_res = $signed(a) >>> b[SHW-1:0];
            4'd8: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'd9: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            4'd10: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
        // multiplicand is pre-shifted each step, so the accumulator adds it when the current multiplier LSB is set
        prod = acc + (mplier[0] ? mcand : '0);
        last = count == SHW'(WIDTH-1);
        out_free = !out_valid || out_ready;
        in_ready = (state == S_IDLE) && out_free;
        accept = in_valid && in_ready;
        mul_done = (state == S_MUL) && last && out_free;
        load = (accept && sel != 4'd10) || mul_done;
        res_d = mul_done ? prod[WIDTH-1:0] : alu_res;
        state_d = (state == S_IDLE) ? ((accept && sel == 4'd10) ? S_MUL : S_IDLE)
                                    : (mul_done ? S_IDLE : S_MUL);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            mcand <= '0;
            mplier <= '0;
            acc <= '0;
            count <= '0;
            out_valid <= 1'b0;
            result <= '0;
            carry <= 1'b0;
            overflow <= 1'b0;
            zero <= 1'b0;
            negative <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_d;
            if (accept && sel == 4'd10) begin
                mcand <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                acc <= '0;
                count <= '0;
            end else if (state == S_MUL && (!last || out_free)) begin
                // on the last bit with a full output register everything holds so the final add is retried
                acc <= prod;
                mcand <= mcand << 1;
                mplier <= mplier >> 1;
                count <= last ? count : count + 1'b1;
            end
            if (load) begin
                result <= res_d;
                carry <= mul_done ? 1'b0 : alu_c;
                overflow <= mul_done ? |prod[2*WIDTH-1:WIDTH] : alu_v;
                zero <= res_d == '0;
                negative <= res_d[WIDTH-1];
                illegal <= mul_done ? 1'b0 : alu_ill;
            end
            out_valid <= load ? 1'b1 : (out_ready ? 1'b0 : out_valid);
        end
    end
endmodule
